// File: rtl/bus_xcvr_arb_pkg.sv
// Shared definitions for the bus transceiver arbiter: FSM state encodings
// and transceiver direction constants, plus a small mapping helper.
package bus_xcvr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TURN  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    localparam logic DIR_BA = 1'b0;
    localparam logic DIR_AB = 1'b1;

    // A requester's wr bit selects the transceiver direction it needs.
    function automatic logic dirOf(input logic wrBit);
        return wrBit ? DIR_AB : DIR_BA;
    endfunction

endpackage

// File: rtl/bus_xcvr_arb_rr_pick.sv
// Round-robin picker: returns the first set request bit at or above ptr_i,
// wrapping modulo NREQ. Purely combinational.
module rr_pick
    import bus_xcvr_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [PW-1:0]   winner_o,
    output logic            valid_o
);

    logic [PW:0] sum;

    // Scan from farthest to nearest so the nearest set bit to ptr_i wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        sum      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            if (req_i[sum[PW-1:0]]) begin
                winner_o = sum[PW-1:0];
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_xcvr_arb.sv
// Round-robin arbiter/sequencer for a shared tristate transceiver segment.
// Guarantees break-before-make and inserts TURN dead cycles on direction
// reversal. Optional burst limit enabled by BUS_XCVR_ARB_BURST_LIMIT_EN.
module bus_xcvr_arb
    import bus_xcvr_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int TURN     = 1,
    parameter int MAXBURST = 16
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] wr,
    output logic [NREQ-1:0] gnt,
    output logic            dir,
    output logic            g_,
    output logic            busy
);

    localparam int PW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [3:0]      tcnt_q, tcnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            dir_q, dir_d;
    logic            g_q, g_d;
    logic [PW-1:0]   winner;
    logic            winValid;
    logic            burstDone;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .valid_o  (winValid)
    );

`ifdef BUS_XCVR_ARB_BURST_LIMIT_EN
    logic [7:0] bcnt_q, bcnt_d;

    // Grant-cycle counter: 1 on the first GRANT cycle, +1 per further cycle.
    always_comb begin
        bcnt_d = 8'd1;
        if (state_q == ST_GRANT && state_d == ST_GRANT) begin
            bcnt_d = bcnt_q + 8'd1;
        end
    end

    // Burst counter register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            bcnt_q <= 8'd0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    assign burstDone = (bcnt_q == 8'(MAXBURST));
`else
    assign burstDone = 1'b0;
`endif

    // Next-state and registered-output logic for the IDLE/TURN/GRANT sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        tcnt_d  = tcnt_q;
        gnt_d   = gnt_q;
        dir_d   = dir_q;
        g_d     = g_q;
        unique case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                g_d   = 1'b1;
                if (winValid) begin
                    owner_d = winner;
                    ptr_d   = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
                    dir_d   = dirOf(wr[winner]);
                    if (dirOf(wr[winner]) == dir_q || TURN == 0) begin
                        state_d       = ST_GRANT;
                        gnt_d[winner] = 1'b1;
                        g_d           = 1'b0;
                    end else begin
                        state_d = ST_TURN;
                        tcnt_d  = 4'(TURN);
                    end
                end
            end
            ST_TURN: begin
                gnt_d = '0;
                g_d   = 1'b1;
                if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                    tcnt_d  = 4'd0;
                end else if (tcnt_q <= 4'd1) begin
                    state_d        = ST_GRANT;
                    tcnt_d         = 4'd0;
                    gnt_d[owner_q] = 1'b1;
                    g_d            = 1'b0;
                end else begin
                    tcnt_d = tcnt_q - 4'd1;
                end
            end
            ST_GRANT: begin
                if (!req[owner_q] || burstDone) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    g_d     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                g_d     = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            tcnt_q  <= 4'd0;
            gnt_q   <= '0;
            dir_q   <= DIR_BA;
            g_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            tcnt_q  <= tcnt_d;
            gnt_q   <= gnt_d;
            dir_q   <= dir_d;
            g_q     <= g_d;
        end
    end

    assign gnt  = gnt_q;
    assign dir  = dir_q;
    assign g_   = g_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_xcvr_arb.sv
// Self-checking bench for bus_xcvr_arb: directed scenarios plus randomized
// traffic compared against a tenure-level reference model.
module tb_bus_xcvr_arb;

    localparam int NREQ     = 4;
    localparam int TURN     = 2;
    localparam int MAXBURST = 4;

    logic            clk  = 1'b0;
    logic            rst_ = 1'b1;
    logic [NREQ-1:0] req  = '0;
    logic [NREQ-1:0] wr   = '0;
    logic [NREQ-1:0] gnt;
    logic            dir;
    logic            g_;
    logic            busy;

    int testCount = 0;
    int failCount = 0;

    // Reference model: current owner (-1 = none), dead cycles still to wait,
    // the bus direction, the rotation start point and grant cycles so far.
    int   mOwner;
    int   mWait;
    int   mPtr;
    int   mBurst;
    logic mDir;

    logic prevG;
    logic prevDir;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    bus_xcvr_arb #(
        .NREQ     (NREQ),
        .TURN     (TURN),
        .MAXBURST (MAXBURST)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .req  (req),
        .wr   (wr),
        .gnt  (gnt),
        .dir  (dir),
        .g_   (g_),
        .busy (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic bitAt(input logic [NREQ-1:0] v, input int idx);
        logic [NREQ-1:0] s;
        s = v >> idx;
        return s[0];
    endfunction

    function automatic void modelReset();
        mOwner = -1;
        mWait  = 0;
        mPtr   = 0;
        mBurst = 0;
        mDir   = 1'b0;
    endfunction

    function automatic void modelStep(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w);
        bit expired;
        expired = 1'b0;
        if (mOwner < 0) begin
            for (int i = 0; i < NREQ; i++) begin
                int c;
                c = (mPtr + i) % NREQ;
                if (mOwner < 0 && bitAt(r, c)) begin
                    mOwner = c;
                    mPtr   = (c + 1) % NREQ;
                    if (bitAt(w, c) == mDir || TURN == 0) begin
                        mWait  = 0;
                        mBurst = 1;
                    end else begin
                        mWait = TURN;
                    end
                    mDir = bitAt(w, c);
                end
            end
        end else if (mWait > 0) begin
            if (!bitAt(r, mOwner)) begin
                mOwner = -1;
            end else begin
                mWait--;
                mBurst = 1;
            end
        end else begin
`ifdef BUS_XCVR_ARB_BURST_LIMIT_EN
            expired = (mBurst >= MAXBURST);
`endif
            if (!bitAt(r, mOwner) || expired) begin
                mOwner = -1;
            end else begin
                mBurst++;
            end
        end
    endfunction

    function automatic logic [NREQ-1:0] expGnt();
        logic [NREQ-1:0] e;
        e = '0;
        if (mOwner >= 0 && mWait == 0) begin
            e = NREQ'(1) << mOwner;
        end
        return e;
    endfunction

    task automatic compareAll();
        logic [NREQ-1:0] eg;
        eg = expGnt();
        checkOutput("gnt", 32'(gnt), 32'(eg));
        checkOutput("g_", 32'(g_), 32'(eg == '0));
        checkOutput("dir", 32'(dir), 32'(mDir));
        checkOutput("busy", 32'(busy), 32'(mOwner >= 0));
        checkOutput("onehot0", 32'($onehot0(gnt)), 32'd1);
        checkOutput("g_vs_gnt", 32'(g_), 32'(gnt == '0));
        if (!prevG && !g_) begin
            checkOutput("dir_frozen", 32'(dir), 32'(prevDir));
        end
        prevG   = g_;
        prevDir = dir;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w);
        @(negedge clk);
        req = r;
        wr  = w;
        @(posedge clk);
        modelStep(r, w);
        #1;
        compareAll();
    endtask

    task automatic doReset();
        rst_ = 1'b0;
        req  = '1;
        wr   = '0;
        #1;
        checkOutput("rst_async_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_async_g_", 32'(g_), 32'd1);
        checkOutput("rst_async_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_g_", 32'(g_), 32'd1);
        checkOutput("rst_dir", 32'(dir), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        req  = '0;
        rst_ = 1'b1;
        modelReset();
        prevG   = 1'b1;
        prevDir = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] active;
        logic [NREQ-1:0] lastG;
        logic [NREQ-1:0] order[$];
        int              gaps[$];
        int              idleRun;
        int              run;
        bit              done;
        logic [NREQ-1:0] rv;

        modelReset();
        prevG   = 1'b1;
        prevDir = 1'b0;
        #2;
        doReset();

        // Same direction grant and release.
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("t2_gnt", 32'(gnt), 32'h1);
        checkOutput("t2_g_", 32'(g_), 32'd0);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("t2_rel_gnt", 32'(gnt), 32'd0);
        checkOutput("t2_rel_busy", 32'(busy), 32'd0);

        // Reversal with TURN dead cycles, then wr change ignored in GRANT.
        applyStimulus(4'b0001, 4'b0001);
        checkOutput("t3_e1_dir", 32'(dir), 32'd1);
        checkOutput("t3_e1_busy", 32'(busy), 32'd1);
        checkOutput("t3_e1_gnt", 32'(gnt), 32'd0);
        applyStimulus(4'b0001, 4'b0001);
        checkOutput("t3_e2_gnt", 32'(gnt), 32'd0);
        applyStimulus(4'b0001, 4'b0001);
        checkOutput("t3_e3_gnt", 32'(gnt), 32'h1);
        checkOutput("t3_e3_g_", 32'(g_), 32'd0);
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("t3_frozen_dir", 32'(dir), 32'd1);

        // Reset asserted mid-GRANT.
        doReset();

        // Reversal aborted during turnaround.
        applyStimulus(4'b0001, 4'b0001);
        applyStimulus(4'b0001, 4'b0001);
        applyStimulus(4'b0000, 4'b0001);
        checkOutput("t3b_busy", 32'(busy), 32'd0);
        checkOutput("t3b_gnt", 32'(gnt), 32'd0);
        checkOutput("t3b_dir", 32'(dir), 32'd1);

        // Round-robin rotation; each requester drops after seeing its grant.
        doReset();
        active  = 4'b1111;
        lastG   = '0;
        idleRun = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            applyStimulus(active, 4'b0000);
            if (gnt != '0) begin
                if (gnt != lastG) begin
                    if (order.size() > 0) gaps.push_back(idleRun);
                    order.push_back(gnt);
                end
                idleRun = 0;
                active  = active & ~gnt;
            end else begin
                idleRun++;
            end
            lastG = gnt;
        end
        checkOutput("t4_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size(); i++) begin
            checkOutput($sformatf("t4_order%0d", i), 32'(order[i]), 32'(1) << i);
        end
        for (int i = 0; i < gaps.size(); i++) begin
            checkOutput($sformatf("t4_gap%0d", i), 32'(gaps[i]), 32'd1);
        end

        // Two requesters holding the bus in the same direction.
        run  = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            applyStimulus(4'b0011, 4'b0000);
            if (!done) begin
                if (gnt == 4'b0001) run++;
                else if (run > 0) done = 1'b1;
            end
        end
`ifdef BUS_XCVR_ARB_BURST_LIMIT_EN
        checkOutput("t5_run", 32'(run), 32'(MAXBURST));
`else
        checkOutput("t5_run", 32'(run), 32'd14);
`endif
        applyStimulus(4'b0000, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);

        // Randomized traffic against the model, with one reset in the middle.
        rv = '0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset();
            if ($urandom_range(0, 3) == 0) rv = 4'($urandom_range(0, 15));
            applyStimulus(rv, 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
